nios_2_switch_debounce: RTL and testbench
=========================================

Name: nios_2_switch_debounce

Overview:
Conditioning stage placed between the board slide-switch pins and the switch PIO input port (in_port, 5 bits).
- Synchronises each raw switch bit into the clk domain.
- Debounces each bit independently with a stability counter.
- Provides registered per-bit rise and fall strobes for logic that needs change events without software polling.
- sw_clean connects directly to the PIO in_port.

Parameters:
WIDTH, 5, number of switch bits; must match the PIO in_port width.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a change is accepted (10 ms at 50 MHz); legal range ≥2.
CNT_W, $clog2(DEBOUNCE_CYCLES), per-bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock (same clock as the PIO).
reset_n  input  1  asynchronous active-low reset.
sw_raw  input  WIDTH  raw, asynchronous, bouncing switch pins.
sw_clean  output  WIDTH  debounced level; drives PIO in_port.
sw_rise  output  WIDTH  one-cycle strobe per bit when sw_clean goes 0→1.
sw_fall  output  WIDTH  one-cycle strobe per bit when sw_clean goes 1→0.
sw_changed  output  1  OR of all sw_rise and sw_fall bits, registered with them.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Every flop clears on reset_n=0.
- Reset values: sync stages=0, counters=0, sw_clean=0, sw_rise=0, sw_fall=0, sw_changed=0.
- Synchroniser: two flops per bit (sync1 ← sw_raw, sync2 ← sync1). No logic between the stages.
- Per-bit counter update, each edge:
  - If sync2[i]==sw_clean[i]: cnt[i] ← 0 (any bounce restarts the count).
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: sw_clean[i] ← sync2[i] and cnt[i] ← 0.
  - Else: cnt[i] ← cnt[i]+1.
- Latency: sw_raw[i] changes before edge 1 and then holds stable. sw_clean[i] updates at edge 2+DEBOUNCE_CYCLES. Example: DEBOUNCE_CYCLES=4 gives an update at edge 6.
- Glitch rejection: a pulse on sync2 shorter than DEBOUNCE_CYCLES cycles never reaches sw_clean.
- Strobes: sw_rise[i] and sw_fall[i] are registered on the same edge that updates sw_clean[i]. They are high for exactly one cycle and never high simultaneously for the same bit.
- sw_changed: registered OR of the next-state strobe vectors, aligned with sw_rise and sw_fall.
- Bit independence: bits are fully independent. Simultaneous qualification of several bits produces all of their strobes in the same cycle.
- Counter arithmetic: counters never exceed DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Reset mid-count: all counts are lost and sw_clean returns to 0.
  - A switch held at 1 through reset re-qualifies after 2+DEBOUNCE_CYCLES cycles.
  - That re-qualification produces a sw_rise strobe.
- Elaboration check: DEBOUNCE_CYCLES<2 is a fatal error.

Decomposition:
- Shared package nios_2_io_pkg:
  - SW_WIDTH=5.
  - DEBOUNCE_10MS_50MHZ=500000.
  - A sim-only constant DEBOUNCE_SIM=4.
- One natural sub-module: nios_2_debounce_bit. It contains the two-flop sync, counter, clean flop and rise/fall flops for a single bit, and is instantiated WIDTH times in a generate loop.
- The top level ORs the strobes into sw_changed.

Test Plan:
1. Reset check (DEBOUNCE_CYCLES=4): hold reset_n=0 with sw_raw=5'h1F → all outputs 0. Release reset with sw_raw=5'h1F held → sw_clean=5'h1F at edge 6 after release, with sw_rise=5'h1F and sw_changed=1 for exactly one cycle.
2. Clean step: sw_raw 5'h00→5'h04 before edge 1 → sw_clean=5'h04 at edge 6, sw_rise=5'h04 for one cycle, sw_fall=0.
3. Bounce rejection: toggle sw_raw[0] 1,0,1,0 at 1-cycle intervals, then hold 1 → sw_clean[0] rises exactly 4 cycles after the final stable value reaches sync2, with a single sw_rise[0] strobe.
4. Short glitch: a 3-cycle high pulse on sw_raw[3] → sw_clean[3] stays 0, no strobes.
5. Simultaneous events: bit1 0→1 and bit2 1→0 in the same cycle → same-cycle sw_rise=5'h02, sw_fall=5'h04, single sw_changed pulse.
6. Reset mid-count: sw_raw[4]=1, assert reset_n at edge 4 for 2 cycles → no strobe during reset, sw_clean[4]=0. Qualification restarts from zero and completes at edge 6 after release.

Source files
------------

// File: rtl/nios_2_io_pkg.sv
// Shared constants for the Nios II board I/O conditioning blocks.
//   SW_WIDTH            : slide-switch count, matches the switch PIO in_port width
//   DEBOUNCE_10MS_50MHZ : stable cycles for a 10 ms debounce window at 50 MHz
//   DEBOUNCE_SIM        : short debounce window for simulation only
package nios_2_io_pkg;

    localparam int unsigned SW_WIDTH            = 5;
    localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;
    localparam int unsigned DEBOUNCE_SIM        = 4;

endpackage

// File: rtl/nios_2_debounce_bit.sv
// Single-bit switch conditioner: two-flop synchroniser, stability counter,
// debounced level flop and registered rise/fall strobes.
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   sw_raw    : raw asynchronous switch pin
//   sw_clean  : debounced level
//   sw_rise   : one-cycle strobe when sw_clean goes 0->1
//   sw_fall   : one-cycle strobe when sw_clean goes 1->0
//   rise_nxt  : combinational next-state of sw_rise (for the shared change flag)
//   fall_nxt  : combinational next-state of sw_fall (for the shared change flag)
module nios_2_debounce_bit
    import nios_2_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean_nxt;

    // A bounce back to the accepted level restarts the count; the count never
    // passes CNT_MAX because it is cleared on the qualifying edge.
    always_comb begin
        cnt_nxt   = cnt;
        clean_nxt = sw_clean;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sync2 == sw_clean) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt   = '0;
            clean_nxt = sync2;
            rise_nxt  = sync2;
            fall_nxt  = ~sync2;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            cnt      <= cnt_nxt;
            sw_clean <= clean_nxt;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
        end
    end

endmodule

// File: rtl/nios_2_switch_debounce.sv
// Slide-switch conditioning stage in front of the switch PIO in_port.
// Each bit is synchronised and debounced independently; registered per-bit
// edge strobes and a combined change flag are provided for event-driven logic.
// Ports:
//   clk        : system clock (same as the PIO)
//   reset_n    : asynchronous active-low reset
//   sw_raw     : raw, bouncing switch pins
//   sw_clean   : debounced levels, drives PIO in_port
//   sw_rise    : per-bit one-cycle strobe on sw_clean 0->1
//   sw_fall    : per-bit one-cycle strobe on sw_clean 1->0
//   sw_changed : OR of all strobes, registered alongside them
module nios_2_switch_debounce
    import nios_2_io_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $fatal(1, "nios_2_switch_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_2_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw   (sw_raw[i]),
            .sw_clean (sw_clean[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .rise_nxt (rise_nxt[i]),
            .fall_nxt (fall_nxt[i])
        );
    end

    // Built from next-state strobes so the flag lands in the same cycle as them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_nios_2_switch_debounce.sv
module tb_nios_2_switch_debounce;
    import nios_2_io_pkg::*;

    localparam int unsigned W = SW_WIDTH;
    localparam int unsigned D = DEBOUNCE_SIM;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw  = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    nios_2_switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] samp[$];        // sw_raw as sampled at each edge since reset release
    logic [W-1:0] clean_m = '0;   // reference debounced level
    int unsigned  last_upd[W];    // edge index of each bit's last accepted change

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronised value seen by the debouncer before edge t: the pin as
    // sampled two edges earlier, zero while the synchroniser is still filling.
    function automatic logic [W-1:0] s_at(input int unsigned t);
        if (t < 3) return '0;
        return samp[t-3];
    endfunction

    // Reference model: a bit changes at edge t when the synchronised input has
    // differed from the accepted level on each of the last D edges, all of
    // which lie after the bit's previous change (or reset).
    initial begin
        logic [W-1:0] r;
        logic [W-1:0] f;
        logic [W-1:0] sv;
        int unsigned  t;
        bit           differ;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                samp.delete();
                clean_m = '0;
                for (int i = 0; i < W; i++) last_upd[i] = 0;
            end else begin
                samp.push_back(sw_raw);
                t = samp.size();
                r = '0;
                f = '0;
                for (int i = 0; i < W; i++) begin
                    if (t - last_upd[i] >= D) begin
                        differ = 1'b1;
                        for (int unsigned k = t - D + 1; k <= t; k++) begin
                            sv = s_at(k);
                            if (sv[i] == clean_m[i]) differ = 1'b0;
                        end
                        if (differ) begin
                            clean_m[i]  = ~clean_m[i];
                            r[i]        = clean_m[i];
                            f[i]        = ~clean_m[i];
                            last_upd[i] = t;
                        end
                    end
                end
                if ((r | f) != '0) sbq.push_back('{cyc, r, f});
            end
        end
    end

    // Monitor: level checked every cycle, events popped when sw_changed fires.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("clean_level", sw_clean, clean_m);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missed_event: expected rise=%0h fall=%0h at cycle %0d, sw_changed stayed low", e.rise, e.fall, e.cyc);
            end
            if (sw_changed) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got rise=%0h fall=%0h expected no event (cycle %0d)", sw_rise, sw_fall, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_rise", sw_rise, e.rise);
                    check("event_fall", sw_fall, e.fall);
                end
            end else begin
                check("idle_strobes", sw_rise | sw_fall, '0);
            end
        end
    end

    initial begin
        // 1: reset with all switches on, then re-qualification
        reset_n = 1'b0;
        sw_raw  = '1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check("rst_clean", sw_clean, '0);
        check("rst_rise", sw_rise, '0);
        check("rst_fall", sw_fall, '0);
        check("rst_changed", sw_changed, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t1_before_edge6", sw_clean, '0);
        @(posedge clk); #1;
        check("t1_clean", sw_clean, 5'h1F);
        check("t1_rise", sw_rise, 5'h1F);
        check("t1_changed", sw_changed, 1'b1);
        @(posedge clk); #1;
        check("t1_changed_once", sw_changed, 1'b0);
        check("t1_rise_once", sw_rise, '0);

        // 2: clean step on bit 2
        @(negedge clk);
        sw_raw = '0;
        repeat (10) @(negedge clk);
        sw_raw = W'(5'h04);
        repeat (6) @(posedge clk); #1;
        check("t2_clean", sw_clean, 5'h04);
        check("t2_rise", sw_rise, 5'h04);
        check("t2_fall", sw_fall, '0);

        // 3: bounce on bit 0 settling high
        @(negedge clk); sw_raw[0] = 1'b1;
        @(negedge clk); sw_raw[0] = 1'b0;
        @(negedge clk); sw_raw[0] = 1'b1;
        @(negedge clk); sw_raw[0] = 1'b0;
        @(negedge clk); sw_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("t3_clean", sw_clean, 5'h05);

        // 4: 3-cycle glitch on bit 3
        sw_raw[3] = 1'b1;
        repeat (3) @(negedge clk);
        sw_raw[3] = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_clean", sw_clean, 5'h05);

        // 5: bit 1 rises and bit 2 falls together
        sw_raw = W'(5'h03);
        repeat (6) @(posedge clk); #1;
        check("t5_clean", sw_clean, 5'h03);
        check("t5_rise", sw_rise, 5'h02);
        check("t5_fall", sw_fall, 5'h04);
        check("t5_changed", sw_changed, 1'b1);

        // 6: reset in the middle of bit 4 qualifying
        repeat (4) @(negedge clk);
        sw_raw = W'(5'h13);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_clean", sw_clean, '0);
        check("t6_rst_changed", sw_changed, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t6_before_edge6", sw_clean, '0);
        @(posedge clk); #1;
        check("t6_clean", sw_clean, 5'h13);
        check("t6_rise", sw_rise, 5'h13);

        // Random bouncing with occasional resets
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        repeat (20) @(negedge clk);
        check("leftover_events", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
